fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 87 ++++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared core definitions used by the fetch path.
//   XLEN_DEF     : default address / PC width
//   RESET_PC_DEF : default first fetch address after reset
//   NOP_INSTR    : canonical NOP (addi x0, x0, 0) shown on an idle decode port
package rv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer: DEPTH-entry synchronous FIFO with a registered head.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : empty the buffer and reset both pointers this edge
//   push/push_data : write one entry (ignored when full without a pop)
//   pop            : consume the head (ignored when empty)
//   head_valid     : buffer non-empty
//   head_data      : entry at the read pointer, straight from storage
//   count          : current fill level
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}},
    localparam int              CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int          PW     = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard against overflow/underflow; a push at full is only legal alongside a pop.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (count_r != {CW{1'b0}}) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        if ((count_r != FULL_C) || pop_ok_s) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and fill level. Storage is reset so the idle head shows RESET_DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_DATA;
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_valid = (count_r != {CW{1'b0}});
    assign head_data  = mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches under a credit rule,
// tracks in-flight requests and their PCs, drops wrong-path responses after a
// redirect and buffers returned words for the decoder.
//   clk, reset                     : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr: fetch request handshake and address
//   imem_rsp_valid, imem_rsp_data  : in-order instruction responses
//   redirect_valid, redirect_pc    : branch/jump redirect (pc[1:0] ignored)
//   instr_valid/ready, instr, instr_pc : buffered head to the decoder
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN - 3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_r;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   drop_r;
    logic [XLEN-1:0] pcq_r [DEPTH];
    logic [PW-1:0]   pcq_wr_r;
    logic [PW-1:0]   pcq_rd_r;

    logic [CW-1:0]   count_s;
    logic [CW-1:0]   inflight_next_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            rsp_s;
    logic            discard_s;
    logic            push_s;
    logic            pop_s;
    logic            unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Handshake decode. Credits count both in-flight and buffered words so every
    // response is guaranteed a buffer slot.
    always_comb begin
        req_valid_s = 1'b0;
        if (!reset && !redirect_valid &&
            (({1'b0, inflight_r} + {1'b0, count_s}) < DEPTH_C)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s  = req_valid_s && imem_req_ready;
        rsp_s     = imem_rsp_valid && !reset && (inflight_r != {CW{1'b0}});
        discard_s = redirect_valid || (drop_r != {CW{1'b0}});
        push_s    = rsp_s && !discard_s;
        pop_s     = instr_valid && instr_ready;
    end

    // Next in-flight count; also the number of responses a redirect must drop.
    always_comb begin
        case ({accept_s, rsp_s})
            2'b10:   inflight_next_s = inflight_r + 1'b1;
            2'b01:   inflight_next_s = inflight_r - 1'b1;
            default: inflight_next_s = inflight_r;
        endcase
    end

    // Fetch PC: reset, redirect (forced word aligned), or advance on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (accept_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    // In-flight and wrong-path drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
        end else begin
            inflight_r <= inflight_next_s;
            if (redirect_valid) begin
                drop_r <= inflight_next_s;
            end else if (rsp_s && (drop_r != {CW{1'b0}})) begin
                drop_r <= drop_r - 1'b1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // PC queue mirrors the in-flight requests; every response pops it, kept or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcq_r[i] <= RESET_PC;
            end
            pcq_wr_r <= {PW{1'b0}};
            pcq_rd_r <= {PW{1'b0}};
        end else begin
            if (accept_s) begin
                pcq_r[pcq_wr_r] <= pc_r;
                pcq_wr_r        <= pcq_wr_r + 1'b1;
            end
            if (rsp_s) begin
                pcq_rd_r <= pcq_rd_r + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH      (32 + XLEN),
        .DEPTH      (DEPTH),
        .RESET_DATA ({NOP_INSTR, RESET_PC})
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  ({imem_rsp_data, pcq_r[pcq_rd_r]}),
        .pop        (pop_s),
        .head_valid (instr_valid),
        .head_data  ({instr, instr_pc}),
        .count      (count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t  tbl[$];
    mreq_t mq[$];
    int    cyc;
    int    lat;
    int    n_vec;
    int    n_err;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rdy, input logic rv,
                       input logic [31:0] addr, input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc;
        tbl.push_back(v);
    endtask

    // Memory model: in-order responses after lat cycles; reset clears it.
    task automatic drive_mem();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(mq[0].addr);
                void'(mq.pop_front());
            end
        end
        if (reset) mq.delete();
        #1;
    endtask

    task automatic advance();
        mreq_t m;
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        drive_mem();
        advance();
    endtask

    task automatic wait_iv(input string nm, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive_mem();
            if (instr_valid) begin
                chk({nm, " pc"}, instr_pc, exp_pc);
                chk({nm, " word"}, instr, word(exp_pc));
                found = 1'b1;
            end
            advance();
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, instr_valid never high, expected pc %h", nm, exp_pc);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; lat = 1;
        reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Reset release, 1-cycle memory, then 10-cycle decoder stall and release.
        add(1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00);
        add(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
        add(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
        add(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
        add(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
        add(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
        add(1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C);
        add(1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C);
        for (int k = 0; k < 8; k++) add(1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C);
        add(1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C);
        add(1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);
        add(1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14);
        add(1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18);
        add(1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C);
        add(1'b0, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20);

        tick(); tick();
        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            instr_ready = tbl[i].rdy;
            drive_mem();
            chk($sformatf("row%0d req_valid", i), imem_req_valid, tbl[i].rv);
            chk($sformatf("row%0d addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("row%0d instr_valid", i), instr_valid, tbl[i].iv);
            if (tbl[i].iv) begin
                chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].ipc);
                chk($sformatf("row%0d instr", i), instr, word(tbl[i].ipc));
            end
            if (tbl[i].rst) begin
                chk($sformatf("row%0d reset instr", i), instr, 32'h0000_0013);
                chk($sformatf("row%0d reset instr_pc", i), instr_pc, 32'h0000_0000);
            end
            advance();
        end

        // 3-cycle memory: redirect to 0x100 with two requests in flight.
        lat = 3; reset = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        drive_mem();
        chk("redir3 req_valid", imem_req_valid, 32'h0);
        advance();
        redirect_valid = 1'b0;
        drive_mem();
        chk("redir3 addr", imem_addr, 32'h0000_0100);
        advance();
        wait_iv("redir3 first", 32'h0000_0100);
        wait_iv("redir3 second", 32'h0000_0104);

        // Redirect to 0x203 coincident with response, push and pop.
        lat = 1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        drive_mem();
        chk("redir1 req_valid", imem_req_valid, 32'h0);
        advance();
        redirect_valid = 1'b0;
        drive_mem();
        chk("redir1 flush instr_valid", instr_valid, 32'h0);
        chk("redir1 req_valid after", imem_req_valid, 32'h1);
        chk("redir1 aligned addr", imem_addr, 32'h0000_0200);
        advance();
        drive_mem();
        chk("redir1 no stale", instr_valid, 32'h0);
        chk("redir1 addr+4", imem_addr, 32'h0000_0204);
        advance();
        drive_mem();
        chk("redir1 first valid", instr_valid, 32'h1);
        chk("redir1 first pc", instr_pc, 32'h0000_0200);
        chk("redir1 first word", instr, word(32'h0000_0200));
        advance();
        drive_mem();
        chk("redir1 second pc", instr_pc, 32'h0000_0204);
        advance();

        // Address held while memory stalls, fill buffer, then reset mid-stream.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
        drive_mem();
        chk("stall req_valid", imem_req_valid, 32'h1);
        chk("stall addr0", imem_addr, 32'h0);
        advance();
        drive_mem();
        chk("stall addr held", imem_addr, 32'h0);
        advance();
        imem_req_ready = 1'b1;
        repeat (8) tick();
        drive_mem();
        chk("full instr_valid", instr_valid, 32'h1);
        chk("full req_valid", imem_req_valid, 32'h0);
        chk("full head pc", instr_pc, 32'h0);
        advance();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_mem();
        chk("post-rst instr_valid", instr_valid, 32'h0);
        chk("post-rst req_valid", imem_req_valid, 32'h1);
        chk("post-rst addr", imem_addr, 32'h0);
        chk("post-rst instr", instr, 32'h0000_0013);
        chk("post-rst instr_pc", instr_pc, 32'h0);
        advance();
        instr_ready = 1'b1;
        wait_iv("post-rst first", 32'h0000_0000);
        wait_iv("post-rst second", 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
